// File: rtl/seg7_frame_decoder.sv
// Samples a multiplexed active-low 7-segment bus, decodes each stable digit and
// presents whole frames with a valid/ack handshake. Hex letters need SEG7_HEX_EN.
module seg7_frame_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    input  logic                  frame_ack,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid,
    output logic                  overrun
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]        seg_s1_reg, seg_s2_reg, seg_prev_reg;
    logic [DIGITS-1:0] an_s1_reg, an_s2_reg, an_prev_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              taken_reg;
    logic [DIGITS-1:0] mask_reg;
    logic [0:0]        state_reg;
    logic [3:0]        stg_code_reg  [DIGITS];
    logic              stg_blank_reg [DIGITS];
    logic              stg_err_reg   [DIGITS];
    logic [4*DIGITS-1:0] stg_code_flat;
    logic [DIGITS-1:0] stg_blank_flat, stg_err_flat;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [DIGITS-1:0] blank_reg, err_reg;
    logic              frame_valid_reg, overrun_reg;

    // Result packing: {err, blank, code[3:0]}
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 6'b00_0000;
            7'b1111001: decode = 6'b00_0001;
            7'b0100100: decode = 6'b00_0010;
            7'b0110000: decode = 6'b00_0011;
            7'b0011001: decode = 6'b00_0100;
            7'b0010010: decode = 6'b00_0101;
            7'b0000010: decode = 6'b00_0110;
            7'b1111000: decode = 6'b00_0111;
            7'b0000000: decode = 6'b00_1000;
            7'b0010000: decode = 6'b00_1001;
`ifdef SEG7_HEX_EN
            7'b0001000: decode = 6'b00_1010;
            7'b0000011: decode = 6'b00_1011;
            7'b1000110: decode = 6'b00_1100;
            7'b0100001: decode = 6'b00_1101;
            7'b0000110: decode = 6'b00_1110;
            7'b0001110: decode = 6'b00_1111;
`endif
            7'b1111111: decode = 6'b01_0000;
            default:    decode = 6'b10_0000;
        endcase
    endfunction

    logic              same;
    logic [DIGITS-1:0] an_low;
    logic              an_onehot;
    logic              capture;
    logic [DIGITS-1:0] capture_bits;
    logic [5:0]        dec_word;
    logic              mask_full;

    assign same      = (seg_s2_reg == seg_prev_reg) && (an_s2_reg == an_prev_reg);
    assign an_low    = ~an_s2_reg;
    assign an_onehot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    // Require the current sample to still match so only a fully stable value is taken
    assign capture   = same && (cnt_reg == CNT_MAX) && !taken_reg && an_onehot;
    assign capture_bits = capture ? an_low : '0;
    assign dec_word  = decode(seg_s2_reg);
    assign mask_full = (mask_reg == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_reg   <= '1;
            seg_s2_reg   <= '1;
            seg_prev_reg <= '1;
            an_s1_reg    <= '1;
            an_s2_reg    <= '1;
            an_prev_reg  <= '1;
            cnt_reg      <= '0;
            taken_reg    <= 1'b0;
        end else begin
            seg_s1_reg   <= seg_in;
            seg_s2_reg   <= seg_s1_reg;
            seg_prev_reg <= seg_s2_reg;
            an_s1_reg    <= an_in;
            an_s2_reg    <= an_s1_reg;
            an_prev_reg  <= an_s2_reg;
            if (!same) begin
                cnt_reg   <= '0;
                taken_reg <= 1'b0;
            end else begin
                if (cnt_reg != CNT_MAX)
                    cnt_reg <= cnt_reg + 1'b1;
                if (capture)
                    taken_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                stg_code_reg[i]  <= '0;
                stg_blank_reg[i] <= 1'b1;
                stg_err_reg[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (capture_bits[i]) begin
                    stg_code_reg[i]  <= dec_word[3:0];
                    stg_blank_reg[i] <= dec_word[4];
                    stg_err_reg[i]   <= dec_word[5];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_flat
            assign stg_code_flat[4*gi +: 4] = stg_code_reg[gi];
            assign stg_blank_flat[gi]       = stg_blank_reg[gi];
            assign stg_err_flat[gi]         = stg_err_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_COLLECT;
            mask_reg        <= '0;
            bcd_reg         <= '0;
            blank_reg       <= '1;
            err_reg         <= '0;
            frame_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_COLLECT: begin
                    if (mask_full) begin
                        bcd_reg         <= stg_code_flat;
                        blank_reg       <= stg_blank_flat;
                        err_reg         <= stg_err_flat;
                        frame_valid_reg <= 1'b1;
                        mask_reg        <= capture_bits;
                        state_reg       <= ST_PRESENT;
                    end else begin
                        mask_reg <= mask_reg | capture_bits;
                    end
                end
                default: begin
                    // Ack wins over a simultaneous full mask; the held mask presents next cycle
                    if (frame_ack) begin
                        frame_valid_reg <= 1'b0;
                        mask_reg        <= mask_reg | capture_bits;
                        state_reg       <= ST_COLLECT;
                    end else if (mask_full) begin
                        overrun_reg <= 1'b1;
                        mask_reg    <= capture_bits;
                    end else begin
                        mask_reg <= mask_reg | capture_bits;
                    end
                end
            endcase
        end
    end

    assign bcd_out     = bcd_reg;
    assign blank_out   = blank_reg;
    assign err_out     = err_reg;
    assign frame_valid = frame_valid_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: scans digit patterns on the bus and
// checks frame contents, handshake, overrun and reset behaviour.
module tb_seg7_frame_decoder;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SA = 7'b0001000, BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = BL;
    logic [3:0]  an_in = 4'b1111;
    logic        frame_ack = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out, err_out;
    logic        frame_valid, overrun;

    int checks = 0;
    int errors = 0;

    seg7_frame_decoder #(.DIGITS(4), .STABLE_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .frame_ack(frame_ack), .bcd_out(bcd_out), .blank_out(blank_out),
        .err_out(err_out), .frame_valid(frame_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [6:0] d3);
        drive(4'b1110, d0, 20);
        drive(4'b1101, d1, 20);
        drive(4'b1011, d2, 20);
        drive(4'b0111, d3, 20);
        drive(4'b1111, BL, 4);
    endtask

    task automatic ack_pulse();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_blank", blank_out, 4'hF);
        check("rst_err", err_out, 4'h0);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        tick(2);

        // Two digits captured, then an asynchronous reset mid-frame
        drive(4'b1110, S7, 20);
        drive(4'b1101, S7, 20);
        rst = 1'b1;
        #1;
        check("midrst_bcd", bcd_out, 16'h0000);
        check("midrst_blank", blank_out, 4'hF);
        check("midrst_valid", frame_valid, 1'b0);
        an_in = 4'b1111;
        seg_in = BL;
        tick(2);
        rst = 1'b0;
        tick(4);

        // Frame 1: 1,2,3,4 with a short glitch on digit 2
        drive(4'b1110, S1, 20);
        drive(4'b1101, S2, 20);
        drive(4'b1011, S8, 3);
        drive(4'b1011, S3, 20);
        drive(4'b0111, S4, 20);
        drive(4'b1111, BL, 4);
        check("f1_valid", frame_valid, 1'b1);
        check("f1_bcd", bcd_out, 16'h4321);
        check("f1_blank", blank_out, 4'h0);
        check("f1_err", err_out, 4'h0);
        tick(30);
        check("f1_hold", frame_valid, 1'b1);
        ack_pulse();
        check("f1_acked", frame_valid, 1'b0);
        tick(30);
        check("f1_single", frame_valid, 1'b0);

        // Frame 2: digit 3 blank, digit 0 shows 'A'
        scan(SA, S5, S6, BL);
        check("f2_valid", frame_valid, 1'b1);
        check("f2_blank", blank_out, 4'b1000);
`ifdef SEG7_HEX_EN
        check("f2_bcd", bcd_out, 16'h065A);
        check("f2_err", err_out, 4'b0000);
`else
        check("f2_bcd", bcd_out, 16'h0650);
        check("f2_err", err_out, 4'b0001);
`endif

        // Frame 3 dropped while frame 2 still presented
        check("pre_overrun", overrun, 1'b0);
        scan(S7, S8, S9, S0);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_valid", frame_valid, 1'b1);
        check("ovr_blank", blank_out, 4'b1000);
`ifdef SEG7_HEX_EN
        check("ovr_bcd", bcd_out, 16'h065A);
`else
        check("ovr_bcd", bcd_out, 16'h0650);
`endif
        ack_pulse();
        check("ovr_acked", frame_valid, 1'b0);

        // Frame 4 presented after ack
        scan(S9, S8, S7, S6);
        check("f4_valid", frame_valid, 1'b1);
        check("f4_bcd", bcd_out, 16'h6789);
        check("f4_blank", blank_out, 4'h0);
        check("f4_err", err_out, 4'h0);
        check("f4_overrun", overrun, 1'b1);
        ack_pulse();

        // Multiple enables must not capture anything
        drive(4'b0000, S8, 50);
        check("multi_valid", frame_valid, 1'b0);
        check("multi_err", err_out, 4'h0);
        drive(4'b1110, S5, 20);
        drive(4'b1101, S6, 20);
        drive(4'b1011, S7, 20);
        drive(4'b1111, BL, 4);
        check("partial_valid", frame_valid, 1'b0);
        drive(4'b0111, S8, 20);
        drive(4'b1111, BL, 4);
        check("f5_valid", frame_valid, 1'b1);
        check("f5_bcd", bcd_out, 16'h8765);

        // Overrun only clears on reset
        rst = 1'b1;
        #1;
        check("end_overrun", overrun, 1'b0);
        check("end_valid", frame_valid, 1'b0);
        check("end_bcd", bcd_out, 16'h0000);
        check("end_blank", blank_out, 4'hF);
        tick(2);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Reader for the team's multiplexed active-low 7-segment display bus: samples the segment lines plus the digit-enable strobes and decodes each pattern back to a BCD digit.
- Assembles one value per digit into a frame and presents the frame to downstream logic, such as the UART transmitter, with a valid/ack handshake.
- Used for display loopback checking and for reading external 7-segment drivers.

Parameters:
- DIGITS, 4, number of multiplexed digits per frame.
- STABLE_CYCLES, 8, number of consecutive identical samples required before a digit is captured (minimum 2).
- CNT_W, 4, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines {g,f,e,d,c,b,a}, active-low; 7'b1111111 means blank.
- an_in  input  DIGITS  digit enables, active-low, one-hot when valid; bit 0 is the rightmost digit.
- frame_ack  input  1  consumer accepts the presented frame.
- bcd_out  output  4*DIGITS  decoded codes; digit i occupies bits [4i+3:4i].
- blank_out  output  DIGITS  per-digit blank flag.
- err_out  output  DIGITS  per-digit flag for an unrecognised pattern.
- frame_valid  output  1  frame available; held until frame_ack.
- overrun  output  1  sticky: a completed frame was dropped while frame_valid was high.

Behaviour:
- Reset: the one clock is clk; reset is asynchronous and active-high on rst. Reset is asynchronous assert, clears all state immediately, and applies at any point including mid-frame.
  - bcd_out=0, blank_out=all 1, err_out=0, frame_valid=0, overrun=0.
  - Stability counter=0, capture mask=0, FSM=COLLECT.
- Synchronisation: seg_in and an_in pass through 2-flop synchronisers before any use.
- Stability filter:
  - The synchronised {an,seg} is compared with the previous cycle's value.
  - If different, the counter clears to 0 and the "taken" flag clears.
  - If equal, the counter increments, saturating at STABLE_CYCLES-1.
- Capture condition: all three of counter==STABLE_CYCLES-1, taken==0, and an has exactly one zero bit.
  - Writes the decoded digit into the staging slot selected by an, sets that mask bit, and sets taken.
  - taken guarantees one capture per stable period.
  - If an is all-ones or has multiple zeros, nothing is captured and no error is raised.
- Re-capture of a digit already in the mask overwrites its staging slot with the newest value.
- Decode, for a 7-bit pattern p:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 -> code 0-9.
  - 1111111 -> code 0, blank=1.
  - Any other pattern -> code 0, err=1.
- FSM COLLECT:
  - When the mask becomes all ones, the next clock edge copies staging to bcd_out/blank_out/err_out, sets frame_valid, clears the mask, and moves to PRESENT.
  - Latency is 1 cycle after the final capture, plus 2 synchroniser cycles plus STABLE_CYCLES from the input settling.
- FSM PRESENT:
  - Outputs are held stable.
  - Capture into staging continues.
  - On frame_ack=1: frame_valid is cleared and the FSM returns to COLLECT.
  - If the mask fills while in PRESENT (before ack), the staged frame is discarded, the mask clears, overrun=1, and outputs are unchanged.
  - Mask-full and frame_ack in the same cycle: the ack is honoured first, then the new frame is presented the following cycle (no overrun).
- frame_ack while in COLLECT is ignored.
- overrun clears only on rst.

Optional Feature:
- Macro SEG7_HEX_EN.
- Defined: additionally decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 -> codes 10-15, with err=0.
- Undefined: these patterns decode as errors (code 0, err=1).
- Blank handling is identical in both builds.

Test Plan:
- Reset mid-frame after 2 digits are captured -> all outputs return to reset values; the next 4 clean digits produce exactly one frame.
- Scan digits 1,2,3,4 (an=1110,1101,1011,0111), each held 20 cycles -> frame_valid=1, bcd_out=16'h4321, blank_out=0, err_out=0; frame_valid holds until frame_ack.
- Digit 2 pattern glitches for 3 cycles (< STABLE_CYCLES) before settling at 0110000 -> only code 3 is captured; no error flagged.
- Digit 3 driven 1111111 and digit 0 driven 0001000 -> blank_out[3]=1, err_out[0]=1 (SEG7_HEX_EN undefined), or bcd digit0=4'hA with err_out[0]=0 (defined).
- A second full frame is scanned without frame_ack -> overrun=1, bcd_out keeps the first frame; ack, then a third frame -> frame_valid=1 with the third frame's values.
- an=0000 (multiple enables) held 50 cycles -> no capture, no error, frame_valid stays 0.
